obstacle_rom_arbiter: RTL and testbench

- Shares one single-port obstacle sprite ROM (320x240, 3-bit palette index) among several pixel requesters.
- Requesters are the display scan path, two snake/collision checkers and a minimap renderer.
- Requester 0 (display) has strict priority; the others are served round-robin, with a starvation watchdog.
- Sits between the renderers and the ROM/palette pair; the ROM is clocked by the inverted vga_clk.

---
 rtl/obstacle_rom_arbiter_pkg.sv | 28 ++
 rtl/obstacle_rom_arbiter_if.sv | 26 ++
 rtl/obstacle_rom_arbiter_rr_pick.sv | 27 ++
 rtl/obstacle_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_obstacle_rom_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/obstacle_rom_arbiter_pkg.sv
// Shared constants and types for the obstacle sprite ROM arbiter.
// Requester 0 is the display scan path; 1..N_REQ-1 share the ROM round-robin.
package obstacle_rom_pkg;

  localparam int N_REQ      = 4;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 3;
  localparam int ROM_LAT    = 1;
  localparam int STARVE_MAX = 15;

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef logic [N_REQ-1:0] req_id_t;
  typedef logic [PTR_W-1:0] rr_ptr_t;
  typedef logic [CNT_W-1:0] starve_cnt_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rom_tag_t;

  // Round-robin successor of requester i, skipping index 0.
  function automatic rr_ptr_t next_ptr(input int i);
    return (i >= N_REQ - 1) ? rr_ptr_t'(1) : rr_ptr_t'(i + 1);
  endfunction

endpackage

// File: rtl/obstacle_rom_arbiter_if.sv
// Requester and ROM bus of the obstacle ROM arbiter.
// Handshake: a read transfers on a cycle where req_valid[i] & req_ready[i]; the
// requester holds valid (address may change) until then; rsp_valid[i] marks the
// single cycle rsp_data belongs to requester i, ROM_LAT+1 cycles after transfer.
interface obstacle_rom_arbiter_if;
  import obstacle_rom_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]       rom_address;
  logic [DATA_W-1:0]       rom_q;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_address, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_address, rsp_valid, rsp_data
  );

endinterface

// File: rtl/obstacle_rom_arbiter_rr_pick.sv
// Combinational round-robin pick over requesters 1..N_REQ-1, starting at rr_ptr.
// Requester 0 is never picked here; it is handled by the priority mux.
module obstacle_rom_rr_pick
  import obstacle_rom_pkg::*;
(
  input  req_id_t valid_i,
  input  rr_ptr_t rr_ptr_i,
  output req_id_t grant_o,
  output logic    found_o
);

  always_comb begin
    int idx;
    grant_o = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      // Offset keeps idx inside 1..N_REQ-1 even for an out-of-range pointer.
      idx = ((int'(rr_ptr_i) + N_REQ - 2 + k) % (N_REQ - 1)) + 1;
      if (!found_o && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obstacle_rom_arbiter.sv
// Shares one single-port obstacle sprite ROM among N_REQ pixel requesters:
// display path first, the rest round-robin with a starvation watchdog.
module obstacle_rom_arbiter
  import obstacle_rom_pkg::*;
(
  input  logic                        vga_clk,
  input  logic                        reset_n,
  obstacle_rom_arbiter_if.slave       bus,
  output logic                        starve_seen,
  output rr_ptr_t                     rr_ptr_o,
  output starve_cnt_t [N_REQ-1:0]     starve_cnt_o
);

  rr_ptr_t                  rr_ptr_q;
  starve_cnt_t [N_REQ-1:0]  starve_cnt_q;
  logic                     starve_seen_q;
  logic [ADDR_W-1:0]        rom_address_q;
  rom_tag_t                 acc_tag_q;
  rom_tag_t                 tag_pipe_q [ROM_LAT];
  req_id_t                  rsp_valid_q;
  logic [DATA_W-1:0]        rsp_data_q;

  req_id_t           promoted;
  req_id_t           grant_rr;
  logic              rr_found;
  req_id_t           grant;
  logic [ADDR_W-1:0] addr_sel;
  rr_ptr_t           rr_ptr_d;

  obstacle_rom_rr_pick u_rr_pick (
    .valid_i  (bus.req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant_rr),
    .found_o  (rr_found)
  );

  always_comb begin
    promoted = '0;
    for (int j = 1; j < N_REQ; j++) begin
      promoted[j] = bus.req_valid[j] && (starve_cnt_q[j] == starve_cnt_t'(STARVE_MAX));
    end
  end

  // Grants are suppressed while reset is held so nothing transfers into a clearing pipe.
  always_comb begin
    grant = '0;
    if (!reset_n) begin
      grant = '0;
    end else if (|promoted) begin
      grant = promoted & (~promoted + req_id_t'(1));
    end else if (bus.req_valid[0]) begin
      grant = req_id_t'(1);
    end else if (rr_found) begin
      grant = grant_rr;
    end
  end

  always_comb begin
    addr_sel = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        addr_sel = addr_sel | bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = 1; i < N_REQ; i++) begin
      if (grant[i]) begin
        rr_ptr_d = next_ptr(i);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= rr_ptr_t'(1);
      starve_cnt_q  <= '0;
      starve_seen_q <= 1'b0;
      rom_address_q <= '0;
      acc_tag_q     <= '0;
      for (int p = 0; p < ROM_LAT; p++) begin
        tag_pipe_q[p] <= '0;
      end
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int j = 1; j < N_REQ; j++) begin
        if (grant[j] || !bus.req_valid[j]) begin
          starve_cnt_q[j] <= '0;
        end else if (starve_cnt_q[j] != starve_cnt_t'(STARVE_MAX)) begin
          starve_cnt_q[j] <= starve_cnt_q[j] + starve_cnt_t'(1);
        end
      end
      if (|promoted) begin
        starve_seen_q <= 1'b1;
      end
      if (|grant) begin
        rom_address_q <= addr_sel;
      end
      // acc_tag_q pairs with rom_address_q; the pipe then covers the ROM latency.
      acc_tag_q.valid <= |grant;
      acc_tag_q.id    <= grant;
      tag_pipe_q[0]   <= acc_tag_q;
      for (int p = 1; p < ROM_LAT; p++) begin
        tag_pipe_q[p] <= tag_pipe_q[p-1];
      end
      rsp_valid_q <= tag_pipe_q[ROM_LAT-1].valid ? tag_pipe_q[ROM_LAT-1].id : '0;
      if (tag_pipe_q[ROM_LAT-1].valid) begin
        rsp_data_q <= bus.rom_q;
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.rom_address = rom_address_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign starve_seen     = starve_seen_q;
  assign rr_ptr_o        = rr_ptr_q;
  assign starve_cnt_o    = starve_cnt_q;

endmodule

// File: tb/tb_obstacle_rom_arbiter.sv
// Bench for obstacle_rom_arbiter: hand-derived grant table, corner sequences and
// random legal traffic against a cycle-level reference model.
module tb_obstacle_rom_arbiter;
  import obstacle_rom_pkg::*;

  localparam int BOUND  = STARVE_MAX + N_REQ - 2;
  localparam int DEPTH  = ROM_LAT + 2;
  localparam int ENT_W  = N_REQ + DATA_W;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic                    starve_seen;
  rr_ptr_t                 rr_ptr_o;
  starve_cnt_t [N_REQ-1:0] starve_cnt_o;

  obstacle_rom_arbiter_if bus();

  obstacle_rom_arbiter dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .starve_seen  (starve_seen),
    .rr_ptr_o     (rr_ptr_o),
    .starve_cnt_o (starve_cnt_o)
  );

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[2:0] ^ a[7:5] ^ a[16:14] ^ (a[11:9] + 3'd1);
  endfunction

  // Synchronous sprite ROM: data for the address presented at one edge is ready by the next.
  always @(posedge vga_clk) bus.rom_q <= rom_fn(bus.rom_address);

  // ---------------- reference model + scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int m_rr;
  int m_wait   [N_REQ];
  int m_denied [N_REQ];
  bit m_starve;
  logic [ADDR_W-1:0] m_addr;
  logic [ENT_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] addr_a [N_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 1;
    for (int i = 0; i < N_REQ; i++) begin
      m_wait[i]   = 0;
      m_denied[i] = 0;
    end
    m_starve = 0;
    m_addr   = '0;
    exp_q.delete();
  endtask

  function automatic req_id_t model_grant(input req_id_t v);
    for (int j = 1; j < N_REQ; j++)
      if (v[j] && m_wait[j] >= STARVE_MAX) return req_id_t'(1 << j);
    if (v[0]) return req_id_t'(1);
    for (int k = 0; k < N_REQ - 1; k++) begin
      int j;
      j = 1 + (m_rr - 1 + k) % (N_REQ - 1);
      if (v[j]) return req_id_t'(1 << j);
    end
    return '0;
  endfunction

  // ---------------- driver ----------------
  task automatic do_reset(input int cycles);
    reset_n       = 1'b0;
    bus.req_valid = '1;
    #1;
    check("reset_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rom_address", bus.rom_address, 0);
    check("reset_starve_seen", starve_seen, 0);
    check("reset_rr_ptr", rr_ptr_o, 1);
    repeat (cycles) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive at negedge, check ready, then check registered outputs after the edge.
  task automatic step(input req_id_t v, output req_id_t got);
    req_id_t          g;
    int               gi;
    logic [ENT_W-1:0] e;
    bus.req_valid = v;
    for (int i = 0; i < N_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
    #1;
    g   = model_grant(v);
    got = bus.req_ready;
    check("req_ready", bus.req_ready, g);
    @(posedge vga_clk);
    #1;
    gi = -1;
    for (int i = 0; i < N_REQ; i++) if (g[i]) gi = i;
    for (int j = 1; j < N_REQ; j++) if (v[j] && m_wait[j] >= STARVE_MAX) m_starve = 1;
    if (gi >= 0) begin
      m_addr = addr_a[gi];
      exp_q.push_back({g, rom_fn(addr_a[gi])});
    end else begin
      exp_q.push_back('0);
    end
    if (gi >= 1) check("wait_bound", m_denied[gi] <= BOUND, 1);
    for (int j = 1; j < N_REQ; j++) begin
      if (g[j] || !v[j]) begin
        m_wait[j]   = 0;
        m_denied[j] = 0;
      end else begin
        m_wait[j]   = (m_wait[j] < STARVE_MAX) ? m_wait[j] + 1 : STARVE_MAX;
        m_denied[j] = m_denied[j] + 1;
      end
    end
    if (gi >= 1) m_rr = (gi == N_REQ - 1) ? 1 : gi + 1;
    check("rom_address", bus.rom_address, m_addr);
    if (exp_q.size() == DEPTH) begin
      e = exp_q.pop_front();
      check("rsp_valid", bus.rsp_valid, e[DATA_W +: N_REQ]);
      if (e[DATA_W +: N_REQ] != 0) check("rsp_data", bus.rsp_data, e[DATA_W-1:0]);
    end else begin
      check("rsp_valid_idle", bus.rsp_valid, 0);
    end
    check("starve_seen", starve_seen, m_starve);
    check("rr_ptr", rr_ptr_o, m_rr);
    for (int j = 1; j < N_REQ; j++) check("starve_cnt", starve_cnt_o[j], m_wait[j]);
    @(negedge vga_clk);
  endtask

  // ---------------- grant table (hand-derived from a fresh reset) ----------------
  typedef struct {
    req_id_t valid;
    req_id_t exp_ready;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_id_t got;
    req_id_t pend;

    tbl[0]  = '{4'b1110, 4'b0010};
    tbl[1]  = '{4'b1110, 4'b0100};
    tbl[2]  = '{4'b1110, 4'b1000};
    tbl[3]  = '{4'b1110, 4'b0010};
    tbl[4]  = '{4'b1110, 4'b0100};
    tbl[5]  = '{4'b1110, 4'b1000};
    tbl[6]  = '{4'b0000, 4'b0000};
    tbl[7]  = '{4'b1111, 4'b0001};
    tbl[8]  = '{4'b1111, 4'b0001};
    tbl[9]  = '{4'b1111, 4'b0001};
    tbl[10] = '{4'b1111, 4'b0001};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b1010, 4'b0010};
    tbl[13] = '{4'b1010, 4'b1000};
    tbl[14] = '{4'b0110, 4'b0010};
    tbl[15] = '{4'b0110, 4'b0100};
    tbl[16] = '{4'b0001, 4'b0001};
    tbl[17] = '{4'b1000, 4'b1000};
    tbl[18] = '{4'b1100, 4'b0100};
    tbl[19] = '{4'b1001, 4'b0001};
    tbl[20] = '{4'b1000, 4'b1000};
    tbl[21] = '{4'b0000, 4'b0000};

    model_reset();
    for (int i = 0; i < N_REQ; i++) addr_a[i] = '0;
    bus.req_valid = '0;
    bus.req_addr  = '0;

    // Reset, then a single request from requester 2.
    do_reset(3);
    addr_a[2] = 17'h00140;
    step(4'b0100, got);
    check("single_grant", got, 4'b0100);
    check("single_addr", bus.rom_address, 17'h00140);
    step(4'b0000, got);
    step(4'b0000, got);
    check("single_rsp_valid", bus.rsp_valid, 4'b0100);
    check("single_rsp_data", bus.rsp_data, rom_fn(17'h00140));

    // Grant table: round-robin, display priority, pointer movement.
    do_reset(2);
    for (int t = 0; t < 22; t++) begin
      for (int i = 0; i < N_REQ; i++) addr_a[i] = ADDR_W'($urandom());
      step(tbl[t].valid, got);
      check("table_ready", got, tbl[t].exp_ready);
      if (t == 10) begin
        check("table_cnt1", starve_cnt_o[1], 4);
        check("table_cnt3", starve_cnt_o[3], 4);
        check("table_rr_ptr", rr_ptr_o, 1);
      end
    end

    // Watchdog: requester 1 promoted over requester 0 on cycle 16.
    do_reset(2);
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < N_REQ; i++) addr_a[i] = ADDR_W'($urandom());
      step(4'b0011, got);
      check("wd_grant", got, (c == 16) ? 4'b0010 : 4'b0001);
      if (c == 15) check("wd_starve_before", starve_seen, 0);
      if (c == 16) check("wd_starve_after", starve_seen, 1);
    end

    // Reset while a read is in flight: its response must never appear.
    do_reset(2);
    addr_a[3] = 17'h12C00;
    step(4'b1000, got);
    check("mid_accept", got, 4'b1000);
    step(4'b0000, got);
    do_reset(1);
    for (int c = 0; c < 4; c++) begin
      step(4'b0000, got);
      check("mid_no_rsp", bus.rsp_valid, 0);
    end
    addr_a[1] = 17'd7;
    step(4'b0010, got);
    check("mid_new_accept", got, 4'b0010);
    step(4'b0000, got);
    step(4'b0000, got);
    check("mid_new_rsp", bus.rsp_valid, 4'b0010);
    check("mid_new_data", bus.rsp_data, rom_fn(17'd7));

    // Address change while waiting: the address at the accept edge is used.
    do_reset(2);
    addr_a[0] = 17'h1F000;
    addr_a[2] = 17'd5;
    step(4'b0101, got);
    check("chg_wait", got, 4'b0001);
    addr_a[2] = 17'd9;
    step(4'b0100, got);
    check("chg_grant", got, 4'b0100);
    check("chg_addr", bus.rom_address, 17'd9);
    step(4'b0000, got);
    step(4'b0000, got);
    check("chg_rsp", bus.rsp_valid, 4'b0100);
    check("chg_data", bus.rsp_data, rom_fn(17'd9));

    // Random legal traffic with heavy display load.
    do_reset(2);
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i]) begin
          if ((i == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 3) == 0)) begin
            pend[i]   = 1'b1;
            addr_a[i] = ADDR_W'($urandom());
          end
        end else if ($urandom_range(0, 7) == 0) begin
          addr_a[i] = ADDR_W'($urandom());
        end
      end
      step(pend, got);
      pend = pend & ~got;
    end
    for (int c = 0; c < DEPTH; c++) step(4'b0000, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
